secuenciador_salida: RTL and testbench

Output sequencer for the ALU result path. It captures a wide ALU result of NUM_BLOQUES bytes in a single handshake. It then presents the result one byte at a time on an 8-bit output bus with a valid/ready handshake, and drives the block selector that picks the active byte. It sits between the ALU result register and the external 8-bit bus, and it is the only master of the block-select signal.

---
 rtl/pkg_alu.sv | 15 +
 rtl/contador_bloques.sv | 37 +++
 rtl/secuenciador_salida.sv | 91 +++++++++
 tb/tb_secuenciador_salida.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_alu.sv
// Types, constants and helpers shared by the ALU result path.
package pkg_alu;

    typedef enum logic [0:0] {
        REPOSO,
        ENVIO
    } estado_sec_t;

    localparam int unsigned ANCHO_BYTE = 8;

    function automatic logic paridad_par(input logic [7:0] dato);
        return ^dato;
    endfunction

endpackage

// File: rtl/contador_bloques.sv
// Block index counter: synchronous clear, enable, wraps to 0 after the terminal count.
module contador_bloques #(
    parameter int unsigned NUM_BLOQUES = 4,
    parameter int unsigned ANCHO_SEL   = $clog2(NUM_BLOQUES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 limpiar_i,
    input  logic                 habilitar_i,
    output logic [ANCHO_SEL-1:0] cuenta_o,
    output logic                 ultimo_o
);

    logic [ANCHO_SEL-1:0] cuenta_q, cuenta_d;

    assign ultimo_o = (cuenta_q == ANCHO_SEL'(NUM_BLOQUES - 1));
    assign cuenta_o = cuenta_q;

    // Wrapping at NUM_BLOQUES-1 keeps unused codes unreachable for non power-of-two sizes.
    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar_i) begin
            cuenta_d = '0;
        end else if (habilitar_i) begin
            cuenta_d = ultimo_o ? '0 : cuenta_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/secuenciador_salida.sv
// Output sequencer: captures a wide ALU result and streams it MSB byte first over valid/ready.
// Optional parity output enabled by defining SECUENCIADOR_PARIDAD_EN.
module secuenciador_salida
    import pkg_alu::*;
#(
    parameter int unsigned NUM_BLOQUES = 4,
    localparam int unsigned ANCHO_SEL  = $clog2(NUM_BLOQUES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BLOQUES*8-1:0]      resultado_i,
    input  logic                          resultado_valido_i,
    output logic                          resultado_listo_o,
    input  logic                          cancelar_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_valido_o,
    input  logic                          byte_listo_i,
    output logic [ANCHO_SEL-1:0]          selector_bloque_o,
    output logic                          ultimo_o,
    output logic                          ocupado_o
`ifdef SECUENCIADOR_PARIDAD_EN
    ,
    output logic                          paridad_o
`endif
);

    estado_sec_t estado_q, estado_d;
    logic [NUM_BLOQUES*8-1:0] sombra_q;
    logic [ANCHO_SEL-1:0]     cuenta;
    logic                     cuenta_ultimo;
    logic                     carga;
    logic                     entrega;
    logic                     en_envio;

    assign en_envio = (estado_q == ENVIO);
    // Abort wins over a simultaneous byte handshake, so that byte is never counted.
    assign carga    = resultado_valido_i & resultado_listo_o;
    assign entrega  = byte_valido_o & byte_listo_i & ~cancelar_i;

    contador_bloques #(
        .NUM_BLOQUES (NUM_BLOQUES),
        .ANCHO_SEL   (ANCHO_SEL)
    ) u_contador (
        .clk         (clk),
        .rst_n       (rst_n),
        .limpiar_i   (carga | (en_envio & cancelar_i)),
        .habilitar_i (entrega),
        .cuenta_o    (cuenta),
        .ultimo_o    (cuenta_ultimo)
    );

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            REPOSO: if (carga) estado_d = ENVIO;
            ENVIO: begin
                if (cancelar_i || (entrega && cuenta_ultimo)) estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            sombra_q <= '0;
        end else begin
            estado_q <= estado_d;
            if (carga) sombra_q <= resultado_i;
        end
    end

    assign resultado_listo_o = ~en_envio & ~cancelar_i;
    assign byte_valido_o     = en_envio;
    assign ocupado_o         = en_envio;
    assign ultimo_o          = en_envio & cuenta_ultimo;
    assign selector_bloque_o = cuenta;

    // Block 0 sits in the most significant byte; output is forced to 0 while idle.
    always_comb begin
        byte_o = '0;
        if (en_envio) begin
            byte_o = sombra_q[(NUM_BLOQUES - 1 - int'(cuenta)) * ANCHO_BYTE +: ANCHO_BYTE];
        end
    end

`ifdef SECUENCIADOR_PARIDAD_EN
    assign paridad_o = paridad_par(byte_o);
`endif

endmodule

// File: tb/tb_secuenciador_salida.sv
// Bench for secuenciador_salida: directed scenarios plus random traffic against a queue model.
module tb_secuenciador_salida;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NB*8-1:0] resultado_i = '0;
    logic            resultado_valido_i = 1'b0;
    logic            resultado_listo_o;
    logic            cancelar_i = 1'b0;
    logic [7:0]      byte_o;
    logic            byte_valido_o;
    logic            byte_listo_i = 1'b0;
    logic [1:0]      selector_bloque_o;
    logic            ultimo_o;
    logic            ocupado_o;
`ifdef SECUENCIADOR_PARIDAD_EN
    logic            paridad_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes still to deliver, oldest (block 0) first.
    logic [7:0] pend[$];

    secuenciador_salida #(.NUM_BLOQUES(NB)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .resultado_i        (resultado_i),
        .resultado_valido_i (resultado_valido_i),
        .resultado_listo_o  (resultado_listo_o),
        .cancelar_i         (cancelar_i),
        .byte_o             (byte_o),
        .byte_valido_o      (byte_valido_o),
        .byte_listo_i       (byte_listo_i),
        .selector_bloque_o  (selector_bloque_o),
        .ultimo_o           (ultimo_o),
        .ocupado_o          (ocupado_o)
`ifdef SECUENCIADOR_PARIDAD_EN
        ,
        .paridad_o          (paridad_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit busy;
        busy = (pend.size() != 0);
        check("listo", 32'(resultado_listo_o), 32'(!busy && !cancelar_i));
        check("valido", 32'(byte_valido_o), 32'(busy));
        check("ocupado", 32'(ocupado_o), 32'(busy));
        check("byte", 32'(byte_o), busy ? 32'(pend[0]) : 32'd0);
        check("selector", 32'(selector_bloque_o), busy ? 32'(NB - pend.size()) : 32'd0);
        check("ultimo", 32'(ultimo_o), 32'(pend.size() == 1));
`ifdef SECUENCIADOR_PARIDAD_EN
        check("paridad", 32'(paridad_o), busy ? 32'(^pend[0]) : 32'd0);
`endif
    endtask

    // One clock: apply inputs, compare mid-cycle, advance the model at the edge.
    task automatic step(input bit rv, input logic [NB*8-1:0] res, input bit canc, input bit bl);
        resultado_valido_i = rv;
        resultado_i        = res;
        cancelar_i         = canc;
        byte_listo_i       = bl;
        @(negedge clk);
        check_model();
        @(posedge clk);
        if (pend.size() != 0) begin
            if (canc) pend.delete();
            else if (bl) void'(pend.pop_front());
        end else if (rv && !canc) begin
            for (int b = NB - 1; b >= 0; b--) pend.push_back(res[b*8 +: 8]);
        end
        #1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input int sel, input bit ult);
        check({tag, "_byte"}, 32'(byte_o), 32'(b));
        check({tag, "_sel"}, 32'(selector_bloque_o), 32'(sel));
        check({tag, "_ult"}, 32'(ultimo_o), 32'(ult));
        check({tag, "_val"}, 32'(byte_valido_o), 32'd1);
    endtask

    initial begin
        #3;
        check_model();
        check("rst_byte", 32'(byte_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream of 0xDEADBEEF.
        step(1, 32'hDEADBEEF, 0, 1);
        expect_byte("de", 8'hDE, 0, 0);
        step(0, '0, 0, 1);
        expect_byte("ad", 8'hAD, 1, 0);
        step(0, '0, 0, 1);
        expect_byte("be", 8'hBE, 2, 0);
        step(0, '0, 0, 1);
        expect_byte("ef", 8'hEF, 3, 1);
        step(0, '0, 0, 1);
        check("idle_listo", 32'(resultado_listo_o), 32'd1);
        check("idle_valido", 32'(byte_valido_o), 32'd0);

        // Backpressure on block 1.
        step(1, 32'h12345678, 0, 1);
        step(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0);
            expect_byte("hold", 8'h34, 1, 0);
        end
        step(0, '0, 0, 1);
        expect_byte("bp56", 8'h56, 2, 0);
        step(0, '0, 0, 1);
        expect_byte("bp78", 8'h78, 3, 1);
        step(0, '0, 0, 1);

        // Input changes and load attempts during transfer are ignored.
        step(1, 32'h01020304, 0, 1);
        expect_byte("sh01", 8'h01, 0, 0);
        step(1, 32'hFFFFFFFF, 0, 1);
        expect_byte("sh02", 8'h02, 1, 0);
        check("busy_listo", 32'(resultado_listo_o), 32'd0);
        step(1, 32'hFFFFFFFF, 0, 1);
        expect_byte("sh03", 8'h03, 2, 0);
        step(1, 32'hFFFFFFFF, 0, 1);
        expect_byte("sh04", 8'h04, 3, 1);
        step(0, '0, 0, 1);

        // Abort together with a handshake on block 2.
        step(1, 32'h11223344, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        expect_byte("pre_cancel", 8'h33, 2, 0);
        step(0, '0, 1, 1);
        check("cancel_valido", 32'(byte_valido_o), 32'd0);
        check("cancel_sel", 32'(selector_bloque_o), 32'd0);
        step(1, 32'hA5A5A5A5, 1, 0);
        check("cancel_blocks_load", 32'(ocupado_o), 32'd0);
        step(1, 32'hA5A5A5A5, 0, 1);
        expect_byte("a5", 8'hA5, 0, 0);

        // Asynchronous reset mid-transfer.
        step(0, '0, 0, 1);
        #2;
        rst_n = 1'b0;
        pend.delete();
        #1;
        check("arst_valido", 32'(byte_valido_o), 32'd0);
        check("arst_listo", 32'(resultado_listo_o), 32'd1);
        check("arst_byte", 32'(byte_o), 32'd0);
        check("arst_sel", 32'(selector_bloque_o), 32'd0);
        check("arst_ult", 32'(ultimo_o), 32'd0);
        check("arst_ocup", 32'(ocupado_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        check("post_rst_listo", 32'(resultado_listo_o), 32'd1);

`ifdef SECUENCIADOR_PARIDAD_EN
        step(1, 32'h010307FF, 0, 1);
        check("par0", 32'(paridad_o), 32'd1);
        step(0, '0, 0, 1);
        check("par1", 32'(paridad_o), 32'd0);
        step(0, '0, 0, 1);
        check("par2", 32'(paridad_o), 32'd1);
        step(0, '0, 0, 1);
        check("par3", 32'(paridad_o), 32'd0);
        step(0, '0, 0, 1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(bit'($urandom_range(0, 1)), NB*8'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
